// File: rtl/cla_pkg.sv
// Shared constants and types for the registered carry-lookahead adder.
package cla_pkg;
  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned CLA_GROUP = 4;

  typedef logic [CLA_WIDTH-1:0] cla_operand_t;
endpackage : cla_pkg

// File: rtl/cla32.sv
// Combinational WIDTH-bit carry-lookahead adder built from clb4 groups.
module cla32
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned NG = WIDTH / CLA_GROUP;

  logic [NG:0]   gc;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;

  assign gc[0] = ci;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    clb4 u_clb4 (
      .a  (a[k*CLA_GROUP +: CLA_GROUP]),
      .b  (b[k*CLA_GROUP +: CLA_GROUP]),
      .ci (gc[k]),
      .s  (s[k*CLA_GROUP +: CLA_GROUP]),
      .gg (gg[k]),
      .gp (gp[k])
    );
    assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
  end

  assign co = gc[NG];

endmodule : cla32

// File: rtl/clb4.sv
// 4-bit carry-lookahead group: fully expanded internal carries plus
// group generate/propagate for the next lookahead level.
module clb4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 gg,
  output logic                 gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products from ci, so there is no ripple path.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign s = p ^ c;

endmodule : clb4

// File: rtl/cla_clk.sv
// Registered CLA adder: input registers, cla32 core, output registers
// (two-edge latency, one operand set per cycle).
module cla_clk
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic             rci_q;
  logic [WIDTH-1:0] s_d;
  logic             co_d;
  logic [WIDTH-1:0] s_q;
  logic             co_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_q  <= '0;
      rb_q  <= '0;
      rci_q <= 1'b0;
    end else begin
      ra_q  <= a;
      rb_q  <= b;
      rci_q <= ci;
    end
  end

  cla32 #(.WIDTH(WIDTH)) u_cla32 (
    .a  (ra_q),
    .b  (rb_q),
    .ci (rci_q),
    .s  (s_d),
    .co (co_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

endmodule : cla_clk

// File: tb/tb_cla_clk.sv
// Self-checking bench for cla_clk against an arithmetic two-edge delay model.
module tb_cla_clk;
  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [W-1:0] s;
  logic         co;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: result of the vector captured at the previous edge, and the
  // result currently visible on the outputs.
  logic [W:0] st1_m;
  logic [W:0] out_m;

  cla_clk #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .s     (s),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Optionally pulses reset asynchronously mid-cycle.
  task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic civ, input bit rstv);
    a  = av;
    b  = bv;
    ci = civ;
    if (rstv) begin
      #1 reset = 1'b1;
      #1;
      check("rst_async_s", {1'b0, s}, '0);
      check("rst_async_co", {{W{1'b0}}, co}, '0);
      st1_m = '0;
      out_m = '0;
    end else begin
      reset = 1'b0;
    end
    @(posedge clk);
    if (!reset) begin
      out_m = st1_m;
      st1_m = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
    end
    @(negedge clk);
    check("sum_s", {1'b0, s}, {1'b0, out_m[W-1:0]});
    check("sum_co", {{W{1'b0}}, co}, {{W{1'b0}}, out_m[W]});
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; ci = 1'b0;
    st1_m = '0;
    out_m = '0;
    repeat (2) @(negedge clk);
    check("reset_s", {1'b0, s}, '0);
    check("reset_co", {{W{1'b0}}, co}, '0);

    // Fill the pipeline, then reset mid-cycle and restart.
    step(32'd5, 32'd7, 1'b1, 1'b0);
    step(32'd9, 32'd9, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b1);
    step(32'd38297, 32'd126625, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);

    // Pipelined stream and boundary vectors, one per cycle.
    step(32'd376173, 32'd421542, 1'b0, 1'b0);
    step(32'd111, 32'd6473, 1'b0, 1'b0);
    step(32'd572, 32'd33234, 1'b0, 1'b0);
    step(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    step(32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(32'd100, 32'd100, 1'b1, 1'b0);
    step(32'd2147151326, 32'd332321, 1'b0, 1'b0);
    step(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      step($urandom, $urandom, 1'($urandom_range(1)), ($urandom_range(199) == 0));
    end
    step(32'd0, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_clk
